sbox_share_ctrl: RTL and testbench

SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

---
 rtl/sbox_share_ctrl.sv | 118 +++++++++++
 tb/tb_sbox_share_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_ctrl.sv
// Arbitrates one shared 4-byte S-box between a key-expansion requester (one word)
// and a round-datapath requester (four words), returning per-requester responses.
module sbox_share_ctrl #(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_word,
  output logic         key_resp_valid,
  output logic [31:0]  key_resp_word,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_resp_valid,
  output logic [127:0] st_resp_data,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEY_ISSUE, ST_ISSUE, DRAIN} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic          last_st;   // 1: last grant went to the state requester
  logic [127:0]  st_buf;
  logic [95:0]   st_acc;    // words 0..2; word 3 joins directly on the DRAIN edge
  logic          idle, key_pref, key_hs, st_hs;

  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = d[127:96];
      2'd1:    w = d[95:64];
      2'd2:    w = d[63:32];
      default: w = d[31:0];
    endcase
    return w;
  endfunction

  assign idle     = (state == IDLE);
  // Key wins a tie under fixed priority, or under round-robin when state went last.
  assign key_pref = !PRIO_RR || last_st;

  assign key_req_ready = idle && (!st_req_valid || key_pref);
  assign st_req_ready  = idle && (!key_req_valid || !key_pref);
  assign key_hs        = key_req_valid && key_req_ready;
  assign st_hs         = st_req_valid && st_req_ready;
  assign busy          = !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 2'd0;
      last_st        <= 1'b1;
      st_buf         <= '0;
      st_acc         <= '0;
      sbox_in        <= '0;
      key_resp_valid <= 1'b0;
      key_resp_word  <= '0;
      st_resp_valid  <= 1'b0;
      st_resp_data   <= '0;
    end else begin
      key_resp_valid <= 1'b0;
      st_resp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (key_hs) begin
            state   <= KEY_ISSUE;
            sbox_in <= key_req_word;
            last_st <= 1'b0;
          end else if (st_hs) begin
            state   <= ST_ISSUE;
            idx     <= 2'd0;
            st_buf  <= st_req_data;
            sbox_in <= st_req_data[127:96];
            last_st <= 1'b1;
          end
        end
        KEY_ISSUE: begin
          state   <= DRAIN;
          sbox_in <= '0;
        end
        ST_ISSUE: begin
          // sbox_out now holds the result of the word issued last cycle
          case (idx)
            2'd1:    st_acc[95:64] <= sbox_out;
            2'd2:    st_acc[63:32] <= sbox_out;
            2'd3:    st_acc[31:0]  <= sbox_out;
            default: ;
          endcase
          if (idx == 2'd3) begin
            state   <= DRAIN;
            idx     <= 2'd0;
            sbox_in <= '0;
          end else begin
            idx     <= idx + 2'd1;
            sbox_in <= word_of(st_buf, idx + 2'd1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          if (last_st) begin
            st_resp_valid <= 1'b1;
            st_resp_data  <= {st_acc, sbox_out};
          end else begin
            key_resp_valid <= 1'b1;
            key_resp_word  <= sbox_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: round-robin instance under directed and random traffic,
// plus a fixed-priority instance under continuous contention.
module tb_sbox_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0][7:0] SBP = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] subw(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = SBP[8'hff - w[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] subst(input logic [127:0] d);
    return {subw(d[127:96]), subw(d[95:64]), subw(d[63:32]), subw(d[31:0])};
  endfunction

  // round-robin instance
  logic rst = 1'b1;
  logic kv, kr, krv, sv, sr, srv, bsy;
  logic [31:0] kw, krw, sbi, sbo;
  logic [127:0] sd, srd;

  sbox_share_ctrl #(.PRIO_RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .key_req_valid(kv), .key_req_ready(kr), .key_req_word(kw),
    .key_resp_valid(krv), .key_resp_word(krw),
    .st_req_valid(sv), .st_req_ready(sr), .st_req_data(sd),
    .st_resp_valid(srv), .st_resp_data(srd),
    .sbox_in(sbi), .sbox_out(sbo), .busy(bsy));

  // fixed-priority instance
  logic rst2 = 1'b1;
  logic kv2, kr2, krv2, sv2, sr2, srv2, bsy2;
  logic [31:0] kw2, krw2, sbi2, sbo2;
  logic [127:0] sd2, srd2;

  sbox_share_ctrl #(.PRIO_RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst2),
    .key_req_valid(kv2), .key_req_ready(kr2), .key_req_word(kw2),
    .key_resp_valid(krv2), .key_resp_word(krw2),
    .st_req_valid(sv2), .st_req_ready(sr2), .st_req_data(sd2),
    .st_resp_valid(srv2), .st_resp_data(srd2),
    .sbox_in(sbi2), .sbox_out(sbo2), .busy(bsy2));

  // shared S-box units: registered AES S-box
  always_ff @(posedge clk) begin
    sbo  <= subw(sbi);
    sbo2 <= subw(sbi2);
  end

  int n_cmp = 0, n_bad = 0;
  bit done2 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model of the round-robin instance, keyed by cycle number.
  int cyc = 0, free_cyc = 0;
  bit m_last_st = 1'b1;
  logic [31:0]  m_kword = '0;
  logic [127:0] m_sdata = '0;
  logic [31:0]  e_sbox [int];
  logic [31:0]  e_k [int];
  logic [127:0] e_s [int];

  // One cycle: check outputs against the model, predict accepts, advance past the edge.
  // obs_k/obs_s report the handshakes seen on the DUT.
  task automatic step(output bit obs_k, output bit obs_s);
    bit idle, ek, es;
    @(negedge clk);
    idle = (cyc >= free_cyc);
    ek = idle && (!sv || m_last_st);
    es = idle && (!kv || !m_last_st);
    if (e_k.exists(cyc)) m_kword = e_k[cyc];
    if (e_s.exists(cyc)) m_sdata = e_s[cyc];
    chk("key_ready", kr, ek);
    chk("st_ready", sr, es);
    chk("busy", bsy, !idle);
    chk("sbox_in", sbi, e_sbox.exists(cyc) ? e_sbox[cyc] : 32'h0);
    chk("key_resp_valid", krv, e_k.exists(cyc));
    chk("key_resp_word", krw, m_kword);
    chk("st_resp_valid", srv, e_s.exists(cyc));
    chk("st_resp_data", srd, m_sdata);
    obs_k = kv && kr;
    obs_s = sv && sr;
    if (kv && ek) begin
      e_sbox[cyc+1] = kw;
      e_k[cyc+3] = subw(kw);
      free_cyc = cyc + 3;
      m_last_st = 1'b0;
    end else if (sv && es) begin
      for (int i = 0; i < 4; i++) e_sbox[cyc+1+i] = sd[127-32*i -: 32];
      e_s[cyc+6] = subst(sd);
      free_cyc = cyc + 6;
      m_last_st = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kv = 1'b0;
    sv = 1'b0;
    #1;
    chk("rst_busy", bsy, 1'b0);
    chk("rst_sbox_in", sbi, 32'h0);
    chk("rst_key_resp_valid", krv, 1'b0);
    chk("rst_st_resp_valid", srv, 1'b0);
    chk("rst_key_resp_word", krw, 32'h0);
    chk("rst_st_resp_data", srd, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e_sbox.delete();
    e_k.delete();
    e_s.delete();
    free_cyc = cyc;
    m_last_st = 1'b1;
    m_kword = '0;
    m_sdata = '0;
  endtask

  initial begin : main
    bit ok, os;
    int c0;
    bit grants[$];
    kv = 0; sv = 0; kw = '0; sd = '0;
    do_reset();

    // key alone
    kv = 1'b1; kw = 32'h00010253;
    step(ok, os);
    kv = 1'b0;
    repeat (3) step(ok, os);
    chk("key_alone_word", krw, 32'h637c77ed);

    // state alone
    sv = 1'b1; sd = 128'h00000000_01010101_ffffffff_00010253;
    step(ok, os);
    sv = 1'b0;
    repeat (6) step(ok, os);
    chk("st_alone_data", srd, 128'h63636363_7c7c7c7c_16161616_637c77ed);

    // round-robin contention from reset
    do_reset();
    kv = 1'b1; kw = $urandom;
    sv = 1'b1; sd = {$urandom, $urandom, $urandom, $urandom};
    repeat (20) begin
      step(ok, os);
      if (ok) begin grants.push_back(1'b0); kw = $urandom; end
      if (os) begin grants.push_back(1'b1); sd = {$urandom, $urandom, $urandom, $urandom}; end
    end
    kv = 1'b0; sv = 1'b0;
    chk("rr_grant_count", grants.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("rr_grant_%0d", i), grants[i], (i % 2) != 0);
    repeat (8) step(ok, os);

    // reset during ST_ISSUE idx 2, then a key request
    sv = 1'b1; sd = {$urandom, $urandom, $urandom, $urandom};
    step(ok, os);
    sv = 1'b0;
    repeat (2) step(ok, os);
    do_reset();
    repeat (8) step(ok, os);
    kv = 1'b1; kw = $urandom;
    step(ok, os);
    chk("post_rst_key_acc", ok, 1'b1);
    kv = 1'b0;
    repeat (4) step(ok, os);

    // key raised while busy with a state request
    sv = 1'b1; sd = {$urandom, $urandom, $urandom, $urandom};
    c0 = cyc;
    step(ok, os);
    sv = 1'b0;
    step(ok, os);
    kv = 1'b1; kw = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) step(ok, os);
    chk("busy_hold_key_acc_cycle", cyc - 1 - c0, 6);
    kv = 1'b0;
    repeat (4) step(ok, os);

    // random traffic
    repeat (400) begin
      step(ok, os);
      if (ok || !kv) begin kv = ($urandom_range(0, 2) != 0); kw = $urandom; end
      if (os || !sv) begin sv = ($urandom_range(0, 2) != 0); sd = {$urandom, $urandom, $urandom, $urandom}; end
    end
    kv = 1'b0; sv = 1'b0;
    repeat (8) step(ok, os);

    for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
    chk("fp_block_done", done2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Fixed priority: both requesters always valid; key must win every 3 cycles.
  initial begin : fp
    int c2, free2;
    bit ek;
    logic [31:0] mk2;
    logic [31:0] e2 [int];
    c2 = 0; free2 = 0; mk2 = '0;
    kv2 = 1'b1; sv2 = 1'b1;
    kw2 = $urandom;
    sd2 = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    repeat (24) begin
      @(negedge clk);
      ek = (c2 >= free2);
      if (e2.exists(c2)) mk2 = e2[c2];
      chk("fp_key_ready", kr2, ek);
      chk("fp_st_ready", sr2, 1'b0);
      chk("fp_st_resp_valid", srv2, 1'b0);
      chk("fp_key_resp_valid", krv2, e2.exists(c2));
      chk("fp_key_resp_word", krw2, mk2);
      if (ek) begin
        e2[c2+3] = subw(kw2);
        free2 = c2 + 3;
      end
      @(posedge clk);
      c2++;
      #1;
      if (ek) kw2 = $urandom;
    end
    done2 = 1'b1;
  end

endmodule
